// File: rtl/aes_pkg.sv
// Shared constants, state encoding and byte helpers for the AES-128 key schedule engines.
package aes_pkg;

    localparam int AES_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE,
        FWD,
        EMIT
    } state_e;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] rot8(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_step_bidir.sv
// One AES-128 key-schedule step, forward (dir=1) or inverse (dir=0), around an external S-box.
module aes_key_step_bidir (
    input  logic [127:0] key,
    input  logic [3:0]   rnd,
    input  logic         dir,
    input  logic [31:0]  sbox_in,
    output logic [127:0] next_key,
    output logic [31:0]  sbox_out
);
    import aes_pkg::*;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key;

    always_comb begin
        t        = '0;
        n0       = '0;
        n1       = '0;
        n2       = '0;
        n3       = '0;
        sbox_out = '0;
        if (dir) begin
            sbox_out = w3;
            t        = rot8(sbox_in) ^ {rcon(rnd + 4'd1), 24'h0};
            n0       = w0 ^ t;
            n1       = w1 ^ n0;
            n2       = w2 ^ n1;
            n3       = w3 ^ n2;
        end else begin
            // Undo the word chain first; the previous w3 then feeds the S-box.
            n3       = w3 ^ w2;
            n2       = w2 ^ w1;
            n1       = w1 ^ w0;
            sbox_out = n3;
            t        = rot8(sbox_in) ^ {rcon(rnd), 24'h0};
            n0       = w0 ^ t;
        end
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_sched_inv.sv
// AES-128 inverse key schedule: emits round keys 10 down to 0 over valid/ready,
// optionally deriving round 10 from the cipher key with a forward walk first.
module aes_key_sched_inv #(
    parameter int AES_ROUNDS = 10,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_is_last,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         done,
    output logic [31:0]  sbox_out4,
    input  logic [31:0]  sbox_in4
);
    import aes_pkg::*;

    localparam logic [3:0] LAST_RND = 4'(AES_ROUNDS);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [127:0] step_key;
    logic [31:0]  step_sbox;

    aes_key_step_bidir u_step (
        .key      (key_q),
        .rnd      (rnd_q),
        .dir      (state_q == FWD),
        .sbox_in  (sbox_in4),
        .next_key (step_key),
        .sbox_out (step_sbox)
    );

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        rnd_d       = rnd_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d  = key_in;
                    busy_d = 1'b1;
                    if (key_is_last || !FWD_EN) begin
                        rnd_d       = LAST_RND;
                        state_d     = EMIT;
                        out_valid_d = 1'b1;
                    end else begin
                        rnd_d   = '0;
                        state_d = FWD;
                    end
                end
            end
            FWD: begin
                key_d = step_key;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_RND - 4'd1) begin
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (rnd_q != 4'd0) begin
                        key_d = step_key;
                        rnd_d = rnd_q - 4'd1;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            key_q       <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign out_key   = out_valid_q ? key_q : '0;
    assign out_round = out_valid_q ? rnd_q : '0;
    assign sbox_out4 = (state_q == IDLE) ? '0 : step_sbox;

endmodule

// File: tb/tb_aes_key_sched_inv.sv
// Directed bench for aes_key_sched_inv using the FIPS-197 AES-128 key expansion example.
module tb_aes_key_sched_inv;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         key_is_last;
    logic         busy, out_valid, out_ready, done;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic [31:0]  sbox_out4, sbox_in4;

    logic         start2, out_ready2;
    logic         busy2, out_valid2, done2;
    logic [127:0] out_key2;
    logic [3:0]   out_round2;
    logic [31:0]  sbox_out4_2, sbox_in4_2;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_t [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    // FIPS-197 appendix A.1 round keys, index = round
    logic [127:0] rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    assign sbox_in4   = {sbox_t[sbox_out4[31:24]], sbox_t[sbox_out4[23:16]],
                         sbox_t[sbox_out4[15:8]],  sbox_t[sbox_out4[7:0]]};
    assign sbox_in4_2 = {sbox_t[sbox_out4_2[31:24]], sbox_t[sbox_out4_2[23:16]],
                         sbox_t[sbox_out4_2[15:8]],  sbox_t[sbox_out4_2[7:0]]};

    aes_key_sched_inv #(.AES_ROUNDS(10), .FWD_EN(1'b1)) dut (
        .clock       (clk),
        .reset       (reset),
        .start       (start),
        .key_in      (key_in),
        .key_is_last (key_is_last),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_key     (out_key),
        .out_round   (out_round),
        .done        (done),
        .sbox_out4   (sbox_out4),
        .sbox_in4    (sbox_in4)
    );

    aes_key_sched_inv #(.AES_ROUNDS(10), .FWD_EN(1'b0)) dut_nofwd (
        .clock       (clk),
        .reset       (reset),
        .start       (start2),
        .key_in      (key_in),
        .key_is_last (key_is_last),
        .busy        (busy2),
        .out_valid   (out_valid2),
        .out_ready   (out_ready2),
        .out_key     (out_key2),
        .out_round   (out_round2),
        .done        (done2),
        .sbox_out4   (sbox_out4_2),
        .sbox_in4    (sbox_in4_2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drains all 11 keys with ready high; pulses start when round start_at is shown.
    task automatic expect_seq(input string tag, input int start_at);
        out_ready = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            chk({tag, "_valid"}, 128'(out_valid), 128'(1));
            chk({tag, "_round"}, 128'(out_round), 128'(r));
            chk({tag, "_key"}, out_key, rk[r]);
            if (r == start_at) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk({tag, "_done"}, 128'(done), 128'(1));
        chk({tag, "_valid_off"}, 128'(out_valid), 128'(0));
        chk({tag, "_busy_off"}, 128'(busy), 128'(0));
        chk({tag, "_key_zero"}, out_key, 128'h0);
        chk({tag, "_round_zero"}, 128'(out_round), 128'(0));
        step();
        chk({tag, "_done_pulse"}, 128'(done), 128'(0));
    endtask

    task automatic fwd_phase(input string tag, input int pulse_at);
        key_in      = rk[0];
        key_is_last = 1'b0;
        start       = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk({tag, "_fwd_valid"}, 128'(out_valid), 128'(0));
            chk({tag, "_fwd_busy"}, 128'(busy), 128'(1));
            if (i == pulse_at) begin
                start  = 1'b1;
                key_in = 128'h0123456789abcdef0123456789abcdef;
            end
            step();
            start  = 1'b0;
            key_in = rk[0];
        end
    endtask

    initial begin
        int r;
        int cyc;
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; start2 = 1'b0; key_in = '0; key_is_last = 1'b0;
        out_ready = 1'b0; out_ready2 = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_key", out_key, 128'h0);
        chk("rst_sbox", 128'(sbox_out4), 128'h0);

        // cipher key start: forward walk then full descent
        out_ready = 1'b1;
        fwd_phase("s1", -1);
        expect_seq("s1", -1);

        // last key start, with a start probe on the final handshake
        key_in = rk[10]; key_is_last = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        expect_seq("s2", 0);
        chk("s2_restart_ignored", 128'(busy), 128'(0));

        // ready pattern 1,0,0,1 during EMIT
        key_in = rk[10]; key_is_last = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        r = 10; cyc = 0;
        while (r >= 0 && cyc < 60) begin
            out_ready = pat[cyc % 4];
            chk("s3_valid", 128'(out_valid), 128'(1));
            chk("s3_round", 128'(out_round), 128'(r));
            chk("s3_key", out_key, rk[r]);
            step();
            if (out_ready) r--;
            cyc++;
        end
        chk("s3_handshakes", 128'(r), 128'(-1));
        chk("s3_done", 128'(done), 128'(1));
        out_ready = 1'b1;
        step();

        // start pulses during FWD and EMIT must be ignored
        fwd_phase("s4", 4);
        expect_seq("s4", 6);

        // reset in the middle of EMIT
        key_in = rk[10]; key_is_last = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("s5_round5", 128'(out_round), 128'(5));
        chk("s5_key5", out_key, rk[5]);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s5_busy", 128'(busy), 128'(0));
        chk("s5_valid", 128'(out_valid), 128'(0));
        chk("s5_key", out_key, 128'h0);
        chk("s5_done", 128'(done), 128'(0));
        step();
        chk("s5_done_after", 128'(done), 128'(0));
        key_in = rk[10]; key_is_last = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        expect_seq("s5r", -1);

        // FWD_EN=0 treats a cipher-key start as the last key
        key_in = rk[10]; key_is_last = 1'b0; out_ready2 = 1'b0; start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("s6_valid", 128'(out_valid2), 128'(1));
        chk("s6_round", 128'(out_round2), 128'(10));
        chk("s6_key", out_key2, rk[10]);
        out_ready2 = 1'b1;
        step();
        chk("s6_round9", 128'(out_round2), 128'(9));
        chk("s6_key9", out_key2, rk[9]);
        for (int i = 0; i < 9; i++) step();
        chk("s6_key0", out_key2, rk[0]);
        step();
        chk("s6_done", 128'(done2), 128'(1));
        chk("s6_busy", 128'(busy2), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_inv.md
Name: aes_key_sched_inv

Overview:
- Sequential AES-128 inverse key-schedule engine for the decryption path.
- Starts from either the cipher key (first derives round 10 by a forward walk) or the last round key directly.
- Emits round keys in descending order, round 10 down to round 0, over a valid/ready handshake into round-key storage.
- Uses the same external 4-byte S-box port pair as the forward key-expansion block, so one shared S-box instance serves both.

Parameters:
- AES_ROUNDS, 10, number of rounds; only 10 (AES-128) supported.
- FWD_EN, 1, include forward-derivation phase; when 0, key_is_last is treated as 1.

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- key_in  in  128  cipher key (key_is_last=0) or round-10 key (key_is_last=1)
- key_is_last  in  1  sampled with start
- busy  out  1  high in any state except IDLE
- out_valid  out  1  round key available
- out_ready  in  1  consumer accepts
- out_key  out  128  current round key {w0,w1,w2,w3}, w0 in [127:96]
- out_round  out  4  round index of out_key (10..0)
- done  out  1  one-cycle pulse after round 0 accepted
- sbox_out4  out  32  word to external S-box (combinational from state)
- sbox_in4  in  32  bytewise S-box of sbox_out4, same cycle

Behaviour:
- Reset: state=IDLE; key_r=0, rnd_r=0, out_valid=0, busy=0, done=0. Reset mid-operation aborts immediately; no partial done.
- Rcon(r), r=1..10: 01,02,04,08,10,20,40,80,1B,36; any other r gives 00.
- Forward step (rnd_r -> rnd_r+1), with w = key_r:
  - sbox_out4 = w3; t = rot8(sbox_in4) ^ {Rcon(rnd_r+1),24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- Inverse step (rnd_r -> rnd_r-1):
  - p3 = w3^w2; p2 = w2^w1; p1 = w1^w0; sbox_out4 = p3.
  - p0 = w0 ^ rot8(sbox_in4) ^ {Rcon(rnd_r),24'h0}.
- rot8(x) = {x[23:0], x[31:24]}.
- sbox_out4 = w3 in FWD, p3 in EMIT, 0 in IDLE.
- States:
  - IDLE: on start, key_r <= key_in. If key_is_last=1 or FWD_EN=0: rnd_r <= 10, go to EMIT. Otherwise rnd_r <= 0, go to FWD. Without start, remain in IDLE.
  - FWD: each cycle key_r <= forward step, rnd_r <= rnd_r+1. When rnd_r == 9, transition to EMIT (key_r then holds the round-10 key). Exactly 10 cycles; out_ready is ignored.
  - EMIT: out_valid=1, out_key=key_r, out_round=rnd_r.
    - On out_valid & out_ready with rnd_r != 0: key_r <= inverse step, rnd_r <= rnd_r-1, out_valid stays 1.
    - With rnd_r == 0: go to IDLE, done pulses the next cycle, out_valid drops.
    - Without ready: hold all outputs stable.
- Latency:
  - start at cycle T with key_is_last=1: first key (round 10) valid at T+1.
  - key_is_last=0: first key valid at T+11.
  - With out_ready held high: one key per cycle, 11 keys total.
- start while busy: ignored, no effect on state.
- start in the same cycle as the final handshake: ignored, because state is not yet IDLE. A new start is accepted from the done cycle onward.
- out_key and out_round are 0 whenever out_valid=0.

Decomposition:
- Package aes_pkg:
  - AES_ROUNDS constant
  - rcon lookup function (4b -> 8b)
  - state enum {IDLE, FWD, EMIT}
  - rot8 function
- One combinational sub-module, aes_key_step_bidir:
  - ports: key, rnd, dir, sbox_in → next_key, sbox_out
  - shared by the FWD and EMIT paths so the single S-box port is time-multiplexed by state.

Test Plan:
- Behavioural S-box on the sbox ports. start, key_is_last=0, key_in=2b7e151628aed2a6abf7158809cf4f3c, out_ready=1 -> out_valid at T+11 with out_round=10, out_key=d014f9a8c9ee2589e13f0cc8b6630ca6. Round 1 key = a0fafe1788542cb123a339392a6c7605. Round 0 key = key_in. done pulses one cycle after round 0.
- key_is_last=1, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6 -> round 10 key valid at T+1. Same 11-key sequence as above, ending in 2b7e1516...4f3c.
- out_ready toggled 1,0,0,1 during EMIT -> out_key/out_round held while ready=0. No key skipped or duplicated; 11 handshakes total.
- start pulsed during FWD and during EMIT -> ignored; sequence identical to the first scenario.
- reset asserted at round 5 of EMIT -> next cycle busy=0, out_valid=0, out_key=0, no done pulse. A new start then restarts cleanly.
- FWD_EN=0 with key_is_last=0 -> treated as last key: key valid at T+1 with out_round=10.
